// File: rtl/des_key_pkg.sv
// Shared types and constants for the Triple-DES key loading path.
//   des_key_t        : one 64-bit DES key
//   key_load_state_t : key loader frame states
//   KEY_BYTES        : bytes per DES key
//   byte_odd()       : DES odd-parity test for one key byte
package des_key_pkg;

  typedef logic [63:0] des_key_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } key_load_state_t;

  localparam int KEY_BYTES = 8;

  function automatic logic byte_odd(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/key_byte_shift.sv
// Byte assembly stage for one DES key.
//   clk, n_rst   : clock, asynchronous active-low reset
//   clr          : discard any partial key (frame start/abort)
//   shift_en     : accept rx_data as the next key byte
//   rx_data      : incoming byte, MSB byte of the key first
//   key_word     : previous 7 bytes plus rx_data, i.e. the full key on the last byte
//   last_byte    : shift_en on the 8th byte of a key
//   key_par_fail : some byte of the key so far (including rx_data) had even parity
module key_byte_shift
  import des_key_pkg::*;
#(
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clr,
  input  logic       shift_en,
  input  logic [7:0] rx_data,
  output des_key_t   key_word,
  output logic       last_byte,
  output logic       key_par_fail
);

  // Only the 7 most recent bytes are ever read: the commit word is built
  // from them plus the byte arriving on the same cycle.
  logic [55:0] shreg_q, shreg_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic        par_acc_q, par_acc_d;
  logic        byte_bad;

  assign byte_bad     = CHECK_PARITY && !byte_odd(rx_data);
  assign key_word     = {shreg_q, rx_data};
  assign last_byte    = shift_en && (byte_cnt_q == 3'(KEY_BYTES - 1));
  assign key_par_fail = par_acc_q | byte_bad;

  always_comb begin
    shreg_d    = shreg_q;
    byte_cnt_d = byte_cnt_q;
    par_acc_d  = par_acc_q;
    if (clr) begin
      byte_cnt_d = 3'd0;
      par_acc_d  = 1'b0;
    end else if (shift_en) begin
      shreg_d    = key_word[55:0];
      byte_cnt_d = byte_cnt_q + 3'd1;
      // each key carries its own parity verdict
      par_acc_d  = last_byte ? 1'b0 : (par_acc_q | byte_bad);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg_q    <= '0;
      byte_cnt_q <= '0;
      par_acc_q  <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      byte_cnt_q <= byte_cnt_d;
      par_acc_q  <= par_acc_d;
    end
  end

endmodule

// File: rtl/key_loader.sv
// Assembles NUM_KEYS DES keys from the I2C receive byte stream and loads
// them one by one into the key holders over a shared bus.
//   clk, n_rst : clock, asynchronous active-low reset
//   start      : pulse, new key-load frame
//   abort      : pulse, frame cancelled
//   rx_data    : received byte, qualified by rx_valid
//   key_data   : last committed key (registered, held between commits)
//   key_en     : one-hot, one-cycle load strobe for key holder i
//   key_ready  : all keys of the current frame committed
//   parity_err : sticky, parity failure in the current frame
//   overrun    : sticky, byte received after the frame ended
//
// state | meaning
// IDLE  | no frame open, bytes ignored
// LOAD  | collecting key bytes
// DONE  | all keys committed, further bytes are overrun
// ERR   | parity failure, waiting for start; further bytes are overrun
module key_loader
  import des_key_pkg::*;
#(
  parameter int NUM_KEYS     = 3,
  parameter bit CHECK_PARITY = 1'b1
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [63:0]         key_data,
  output logic [NUM_KEYS-1:0] key_en,
  output logic                key_ready,
  output logic                parity_err,
  output logic                overrun
);

  key_load_state_t     state_q, state_d;
  logic [1:0]          key_idx_q, key_idx_d;
  des_key_t            key_data_q, key_data_d;
  logic [NUM_KEYS-1:0] key_en_q, key_en_d;
  logic                key_ready_q, key_ready_d;
  logic                parity_err_q, parity_err_d;
  logic                overrun_q, overrun_d;

  logic     shift_en;
  logic     clr;
  des_key_t key_word;
  logic     last_byte;
  logic     key_par_fail;

  // start/abort take the cycle; a byte arriving with them is dropped
  assign clr      = start | abort;
  assign shift_en = (state_q == LOAD) && rx_valid && !clr;

  key_byte_shift #(
    .CHECK_PARITY(CHECK_PARITY)
  ) u_shift (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr          (clr),
    .shift_en     (shift_en),
    .rx_data      (rx_data),
    .key_word     (key_word),
    .last_byte    (last_byte),
    .key_par_fail (key_par_fail)
  );

  always_comb begin
    state_d      = state_q;
    key_idx_d    = key_idx_q;
    key_data_d   = key_data_q;
    key_en_d     = '0;
    key_ready_d  = key_ready_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;

    if (start) begin
      state_d      = LOAD;
      key_idx_d    = 2'd0;
      key_ready_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
    end else if (abort) begin
      state_d     = IDLE;
      key_idx_d   = 2'd0;
      key_ready_d = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (last_byte) begin
            if (key_par_fail) begin
              parity_err_d = 1'b1;
              state_d      = ERR;
            end else begin
              key_data_d = key_word;
              for (int i = 0; i < NUM_KEYS; i++) begin
                key_en_d[i] = (key_idx_q == 2'(i));
              end
              key_idx_d = key_idx_q + 2'd1;
              if (key_idx_q == 2'(NUM_KEYS - 1)) begin
                key_ready_d = 1'b1;
                state_d     = DONE;
              end
            end
          end
        end
        DONE, ERR: begin
          if (rx_valid) overrun_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      key_idx_q    <= '0;
      key_data_q   <= '0;
      key_en_q     <= '0;
      key_ready_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_idx_q    <= key_idx_d;
      key_data_q   <= key_data_d;
      key_en_q     <= key_en_d;
      key_ready_q  <= key_ready_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign key_data   = key_data_q;
  assign key_en     = key_en_q;
  assign key_ready  = key_ready_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_key_loader.sv
// Self-checking bench for key_loader: directed scenarios with literal
// expectations plus a randomized phase, all checked every cycle against a
// frame-level reference model.
module tb_key_loader;

  localparam int NK = 3;

  logic          clk = 1'b0;
  logic          n_rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic [63:0]   key_data;
  logic [NK-1:0] key_en;
  logic          key_ready;
  logic          parity_err;
  logic          overrun;

  int checks = 0;
  int errors = 0;

  key_loader #(.NUM_KEYS(NK), .CHECK_PARITY(1'b1)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .abort      (abort),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .key_data   (key_data),
    .key_en     (key_en),
    .key_ready  (key_ready),
    .parity_err (parity_err),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0]  m_bytes[$];
  int          m_keys;
  bit          m_open, m_full, m_bad;
  logic [63:0] e_data;
  logic [NK-1:0] e_en;
  bit          e_ready, e_perr, e_ovr;

  function automatic void model_reset();
    m_bytes.delete();
    m_keys = 0;
    m_open = 0; m_full = 0; m_bad = 0;
    e_data = '0; e_en = '0;
    e_ready = 0; e_perr = 0; e_ovr = 0;
  endfunction

  function automatic void model_step();
    logic [63:0] k;
    bit ok;
    e_en = '0;
    if (!n_rst) begin
      model_reset();
      return;
    end
    if (start) begin
      m_bytes.delete();
      m_keys = 0;
      m_open = 1; m_full = 0; m_bad = 0;
      e_ready = 0; e_perr = 0; e_ovr = 0;
    end else if (abort) begin
      m_bytes.delete();
      m_keys = 0;
      m_open = 0; m_full = 0; m_bad = 0;
      e_ready = 0;
    end else if (rx_valid) begin
      if (m_full || m_bad) begin
        e_ovr = 1;
      end else if (m_open) begin
        m_bytes.push_back(rx_data);
        if (m_bytes.size() == 8) begin
          k = '0;
          ok = 1;
          foreach (m_bytes[i]) begin
            k = {k[55:0], m_bytes[i]};
            if ((^m_bytes[i]) == 1'b0) ok = 0;
          end
          m_bytes.delete();
          if (ok) begin
            e_data = k;
            e_en = NK'(1) << m_keys;
            m_keys++;
            if (m_keys == NK) begin
              m_full = 1; m_open = 0; e_ready = 1;
            end
          end else begin
            m_bad = 1; m_open = 0; e_perr = 1;
          end
        end
      end
    end
  endfunction

  always @(negedge n_rst) model_reset();

  always @(posedge clk) begin
    model_step();
    #1;
    chk("key_data", key_data, e_data);
    chk("key_en", 64'(key_en), 64'(e_en));
    chk("key_ready", 64'(key_ready), 64'(e_ready));
    chk("parity_err", 64'(parity_err), 64'(e_perr));
    chk("overrun", 64'(overrun), 64'(e_ovr));
    chk("key_en_onehot", 64'($countones(key_en) <= 1), 64'(1));
  end

  // ---------------- stimulus helpers ----------------
  localparam logic [63:0] K1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'hFEDCBA9876543210;
  localparam logic [63:0] K3 = 64'h133457799BBCDFF1;

  task automatic cyc(input logic s, input logic a, input logic v, input logic [7:0] d);
    start = s; abort = a; rx_valid = v; rx_data = d;
    @(posedge clk);
    #2;
    start = 1'b0; abort = 1'b0; rx_valid = 1'b0;
  endtask

  task automatic send_key(input logic [63:0] k, input int nbytes, input bit gap);
    logic [63:0] kk;
    kk = k;
    for (int i = 0; i < nbytes; i++) begin
      if (gap) cyc(1'b0, 1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 1'b1, kk[63:56]);
      kk = {kk[55:0], 8'h00};
    end
  endtask

  function automatic logic [7:0] odd_byte(input logic [7:0] r);
    logic [7:0] b;
    b = r;
    b[0] = ~(^r[7:1]);
    return b;
  endfunction

  initial begin
    logic [63:0] stream [3];
    logic [63:0] w;
    logic [7:0] b;
    #1 n_rst = 1'b0;
    #1;
    chk("reset key_data", key_data, 64'h0);
    chk("reset key_en", 64'(key_en), 64'h0);
    chk("reset key_ready", 64'(key_ready), 64'h0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #2;

    // three keys with idle gaps
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    send_key(K1, 8, 1'b1);
    chk("t1 en1", 64'(key_en), 64'h1);
    chk("t1 data1", key_data, K1);
    chk("t1 ready early", 64'(key_ready), 64'h0);
    send_key(K2, 8, 1'b1);
    chk("t1 en2", 64'(key_en), 64'h2);
    chk("t1 data2", key_data, K2);
    send_key(K3, 8, 1'b1);
    chk("t1 en3", 64'(key_en), 64'h4);
    chk("t1 data3", key_data, K3);
    chk("t1 ready", 64'(key_ready), 64'h1);

    // back-to-back bytes
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    stream[0] = K1; stream[1] = K2; stream[2] = K3;
    for (int i = 0; i < 24; i++) begin
      w = stream[i / 8];
      b = w[63 - 8 * (i % 8) -: 8];
      cyc(1'b0, 1'b0, 1'b1, b);
      chk("t2 en", 64'(key_en), (i % 8 == 7) ? (64'h1 << (i / 8)) : 64'h0);
      if (i % 8 == 7) chk("t2 data", key_data, stream[i / 8]);
    end
    // overrun in DONE
    cyc(1'b0, 1'b0, 1'b1, 8'h55);
    chk("t3 overrun", 64'(overrun), 64'h1);
    chk("t3 en", 64'(key_en), 64'h0);
    chk("t3 data", key_data, K3);

    // parity fault in K2
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    send_key(K1, 8, 1'b0);
    send_key(64'hFEDC009876543210, 8, 1'b0);
    chk("t4 en", 64'(key_en), 64'h0);
    chk("t4 perr", 64'(parity_err), 64'h1);
    chk("t4 data", key_data, K1);
    chk("t4 ready", 64'(key_ready), 64'h0);
    cyc(1'b0, 1'b0, 1'b1, 8'h01);
    chk("t4 overrun", 64'(overrun), 64'h1);

    // restart mid-key, start beats rx_valid
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    send_key(K2, 5, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 8'hAB);
    send_key(K3, 8, 1'b0);
    chk("t5 en", 64'(key_en), 64'h1);
    chk("t5 data", key_data, K3);
    chk("t5 perr", 64'(parity_err), 64'h0);

    // abort after K1, then reload
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    send_key(K1, 8, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    chk("t6 ready", 64'(key_ready), 64'h0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    send_key(K2, 8, 1'b0);
    chk("t6 en", 64'(key_en), 64'h1);
    chk("t6 data", key_data, K2);

    // async reset during byte 6 of K2
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    send_key(K1, 8, 1'b0);
    send_key(K2, 5, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h54;
    #1 n_rst = 1'b0;
    #1;
    chk("t7 rst data", key_data, 64'h0);
    chk("t7 rst en", 64'(key_en), 64'h0);
    chk("t7 rst perr", 64'(parity_err), 64'h0);
    rx_valid = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    @(posedge clk); #2;
    send_key(K1, 8, 1'b0);
    chk("t7 ignored en", 64'(key_en), 64'h0);
    chk("t7 ignored data", key_data, 64'h0);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    send_key(K3, 8, 1'b0);
    chk("t7 en", 64'(key_en), 64'h1);

    // randomized phase, checked by the model every cycle
    for (int n = 0; n < 4000; n++) begin
      b = 8'($urandom);
      if ($urandom_range(0, 9) != 0) b = odd_byte(b);
      cyc(($urandom_range(0, 59) == 0), ($urandom_range(0, 149) == 0),
          ($urandom_range(0, 3) != 0), b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
